// File: rtl/ntt_result_streamer.sv
// rtl/ntt_result_streamer.sv - streams NTT result rows from the BRAM banks one coefficient per beat; OUTPUT_BITREV_EN selects bit-reversed row order
module ntt_result_streamer #(
    parameter int RING_DEPTH = 12,
    parameter int PE_DEPTH   = 3,
    parameter int DATA_SIZE  = 32,
    parameter int RD_LAT     = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    output logic [RING_DEPTH-PE_DEPTH+1:0]         raddr,
    output logic                                   ren,
    input  logic [2*(2**PE_DEPTH)*DATA_SIZE-1:0]   rdata,
    output logic [DATA_SIZE-1:0]                   dout,
    output logic                                   dout_valid,
    input  logic                                   dout_ready,
    output logic                                   busy,
    output logic                                   done
);

    localparam int ROW_W    = RING_DEPTH - PE_DEPTH - 1;
    localparam int LANE_W   = PE_DEPTH + 1;
    localparam int ROW_BITS = 2 * (2**PE_DEPTH) * DATA_SIZE;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t               state, state_nxt;
    logic                 clear, finish;
    logic [ROW_W-1:0]     row_cnt, row_sel;
    logic [LANE_W-1:0]    lane_cnt;
    logic [RD_LAT-1:0]    rd_pipe;
    logic                 arrive;
    logic [2:0]           inflight_cnt;
    logic [ROW_BITS-1:0]  fifo_mem [4];
    logic [1:0]           wr_ptr, rd_ptr;
    logic [2:0]           fifo_cnt;
    logic [ROW_BITS-1:0]  head_row;
    logic                 credit_ok, beat, pop;

    assign arrive     = rd_pipe[RD_LAT-1];
    assign credit_ok  = ({1'b0, inflight_cnt} + {1'b0, fifo_cnt}) < 4'd4;
    assign dout_valid = (fifo_cnt != 3'd0);
    assign beat       = dout_valid & dout_ready;
    assign pop        = beat & (&lane_cnt);
    assign head_row   = fifo_mem[rd_ptr];
    assign dout       = dout_valid ? head_row[32'(lane_cnt) * DATA_SIZE +: DATA_SIZE] : '0;
    assign busy       = (state != S_IDLE);
    assign raddr      = ren ? {2'b10, 1'b0, row_sel} : '0;

    // Row select: natural order, or bit-reversed when the option is built in
    always_comb begin
        row_sel = row_cnt;
`ifdef OUTPUT_BITREV_EN
        for (int i = 0; i < ROW_W; i++) begin
            row_sel[i] = row_cnt[ROW_W-1-i];
        end
`endif
    end

    // FSM next state, read issue and run start/finish strobes
    always_comb begin
        state_nxt = state;
        ren       = 1'b0;
        clear     = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_READ;
                    clear     = 1'b1;
                end
            end
            S_READ: begin
                ren = credit_ok;
                if (ren && (&row_cnt)) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((inflight_cnt == 3'd0) && (fifo_cnt == 3'd1) && pop) begin
                    state_nxt = S_IDLE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state register and registered done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= finish;
        end
    end

    // Row/lane counters, read-latency tracker, in-flight count and FIFO pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_cnt      <= '0;
            lane_cnt     <= '0;
            rd_pipe      <= '0;
            inflight_cnt <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
        end else if (clear) begin
            row_cnt      <= '0;
            lane_cnt     <= '0;
            rd_pipe      <= '0;
            inflight_cnt <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
        end else begin
            rd_pipe[0] <= ren;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            if (ren) begin
                row_cnt <= row_cnt + 1'b1;
            end
            case ({ren, arrive})
                2'b10:   inflight_cnt <= inflight_cnt + 3'd1;
                2'b01:   inflight_cnt <= inflight_cnt - 3'd1;
                default: inflight_cnt <= inflight_cnt;
            endcase
            if (arrive) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (beat) begin
                lane_cnt <= lane_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({arrive, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Row FIFO storage; only written when a tracked read returns
    always_ff @(posedge clk) begin
        if (!reset && !clear && arrive) begin
            fifo_mem[wr_ptr] <= rdata;
        end
    end

endmodule

// File: tb/tb_ntt_result_streamer.sv
// tb/tb_ntt_result_streamer.sv - directed self-checking bench for ntt_result_streamer
module tb_ntt_result_streamer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [4:0]   raddr;
    logic         ren;
    logic [127:0] rdata;
    logic [31:0]  dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    ntt_result_streamer #(
        .RING_DEPTH(4),
        .PE_DEPTH  (1),
        .DATA_SIZE (32),
        .RD_LAT    (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .raddr     (raddr),
        .ren       (ren),
        .rdata     (rdata),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Bank model: two-cycle read latency, lane j of physical row p holds 100 + 4p + j
    logic       p1_v;
    logic [4:0] p1_a;
    always @(posedge clk) begin
        p1_v <= ren;
        p1_a <= raddr;
        if (p1_v) begin
            for (int j = 0; j < 4; j++) begin
                rdata[j*32 +: 32] <= 32'(100 + 4 * int'(p1_a[1:0]) + j);
            end
        end else begin
            rdata <= {4{32'hDEADBEEF}};
        end
    end

    function automatic int phys(input int r);
`ifdef OUTPUT_BITREV_EN
        return ((r & 1) << 1) | ((r >> 1) & 1);
`else
        return r;
`endif
    endfunction

    function automatic int exp_val(input int k);
        return 100 + 4 * phys(k / 4) + (k % 4);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready=1, 1: ready toggles 1,0,..., 2: ready=0 for 30 cycles, 3: second start at cycle 7
    task automatic run(input int mode);
        int beats = 0;
        int dones = 0;
        int issued = 0;
        int cyc = 0;
        int done_cyc = -1;
        logic stalled = 1'b0;
        logic [31:0] held = '0;
        start = 1'b1;
        dout_ready = (mode != 2);
        while (cyc < 200 && !(done_cyc >= 0 && cyc >= done_cyc + 4)) begin
            tick();
            cyc++;
            start = (mode == 3 && cyc == 7);
            case (mode)
                1:       dout_ready = (cyc % 2 == 1);
                2:       dout_ready = (cyc > 30);
                default: dout_ready = 1'b1;
            endcase
            #1;
            if (mode == 0 && cyc <= 22) begin
                check("ren_timing", 64'(ren), 64'(cyc >= 1 && cyc <= 4));
                check("valid_timing", 64'(dout_valid), 64'(cyc >= 4 && cyc <= 19));
                check("busy_timing", 64'(busy), 64'(cyc >= 1 && cyc <= 19));
                check("done_timing", 64'(done), 64'(cyc == 20));
                if (ren) check("raddr", 64'(raddr), 64'(16 + phys(cyc - 1)));
            end
            if (ren) begin
                check("outstanding_le4", 64'(issued - beats / 4 < 4), 64'd1);
                issued++;
            end
            if (mode == 2 && cyc == 30) begin
                check("reads_while_stalled", 64'(issued), 64'd4);
                check("ren_off_stalled", 64'(ren), 64'd0);
            end
            if (mode == 2 && cyc > 30 && beats < 16) begin
                check("contiguous_after_release", 64'(dout_valid), 64'd1);
            end
            if (stalled) begin
                check("stall_hold", {31'd0, dout_valid, dout}, {31'd0, 1'b1, held});
            end
            if (dout_valid && dout_ready) begin
                check("beat_value", 64'(dout), 64'(exp_val(beats)));
                beats++;
                stalled = 1'b0;
            end else if (dout_valid) begin
                stalled = 1'b1;
                held = dout;
            end else begin
                stalled = 1'b0;
            end
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
        check("done_seen", 64'(done_cyc >= 0), 64'd1);
        check("beat_count", 64'(beats), 64'd16);
        check("done_count", 64'(dones), 64'd1);
        check("idle_after", 64'(busy), 64'd0);
        if (mode == 0) check("done_cycle", 64'(done_cyc), 64'd20);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        dout_ready = 1'b0;
        #1;
        check("reset_outputs", 64'({raddr, ren, dout, dout_valid, busy, done}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check("idle_outputs", 64'({raddr, ren, dout, dout_valid, busy, done}), 64'd0);

        run(0);
        tick();
        run(1);
        tick();
        run(2);
        tick();
        run(3);
        tick();

        // Reset in the middle of a run, then a clean run from the start
        start = 1'b1;
        dout_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            start = 1'b0;
        end
        check("busy_before_reset", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("reset_mid_outputs", 64'({raddr, ren, dout, dout_valid, busy, done}), 64'd0);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check("idle_after_reset", 64'({ren, dout_valid, busy, done}), 64'd0);
        run(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
